// File: rtl/alu_exec_if.sv
// Request/result bundle between the EX-stage issue logic and alu_exec_unit.
// Signal names match the execution unit's documented port names.
interface alu_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             done_o;
    logic             busy_o;
    logic             illegal_o;

    modport master (
        output start_i, ALUCtrl_i, data1_i, data2_i,
        input  data_o, zero_o, done_o, busy_o, illegal_o
    );

    modport slave (
        input  start_i, ALUCtrl_i, data1_i, data2_i,
        output data_o, zero_o, done_o, busy_o, illegal_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle and/or/add/sub, iterative shift-add multiply that
// asserts busy_o for WIDTH cycles. All results are modulo 2^WIDTH.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 6
) (
    input logic        clk_i,
    input logic        rst_i,
    alu_exec_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StMul} state_e;

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpMul = 3'b011;
    localparam logic [2:0] OpSub = 3'b110;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             illegal_q, illegal_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] alu_res;

    // Partial product for this iteration; carries beyond WIDTH are dropped.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_res = '0;
        case (bus.ALUCtrl_i)
            OpAnd:   alu_res = bus.data1_i & bus.data2_i;
            OpOr:    alu_res = bus.data1_i | bus.data2_i;
            OpAdd:   alu_res = bus.data1_i + bus.data2_i;
            OpSub:   alu_res = bus.data1_i + ~bus.data2_i + 1'b1;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;

        case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    case (bus.ALUCtrl_i)
                        OpAnd, OpOr, OpAdd, OpSub: begin
                            data_d    = alu_res;
                            zero_d    = (alu_res == '0);
                            illegal_d = 1'b0;
                            done_d    = 1'b1;
                        end
                        OpMul: begin
                            mcand_d  = bus.data1_i;
                            mplier_d = bus.data2_i;
                            acc_d    = '0;
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = StMul;
                        end
                        default: begin
                            data_d    = '0;
                            zero_d    = 1'b1;
                            illegal_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end
            StMul: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Fixed WIDTH iterations, no early exit on a zero multiplier.
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    data_d    = acc_next;
                    zero_d    = (acc_next == '0);
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            data_q    <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
        end
    end

    assign bus.data_o    = data_q;
    assign bus.zero_o    = zero_q;
    assign bus.done_o    = done_q;
    assign bus.busy_o    = busy_q;
    assign bus.illegal_o = illegal_q;
endmodule
